// File: rtl/layer_sort_seq.sv
// layer_sort_seq: test sequencer for one per-layer sort core.
// Loads a pattern, shifts it into the core, captures and checks the result.
// Ports: t_clk/rst; start, f_layer_cfg; wr_en/wr_addr/wr_data pattern port;
//   rd_addr/rd_data result read; busy, done, pass, timeout status;
//   core_rst_n, core_f_layer, core_data_in, core_sort_finish, core_data_out.
// Optional macro LAYER_SEQ_TIMEOUT_EN adds the WAIT watchdog and TIMEOUT.

module layer_sort_seq #(
  parameter int WORD_W    = 4,
  parameter int NUM_WORDS = 8
`ifdef LAYER_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT   = 1024
`endif
) (
  input  logic                         t_clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         f_layer_cfg,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_WORDS)-1:0] wr_addr,
  input  logic [WORD_W-1:0]            wr_data,
  input  logic [$clog2(NUM_WORDS)-1:0] rd_addr,
  output logic [WORD_W-1:0]            rd_data,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic                         timeout,
  output logic                         core_rst_n,
  output logic                         core_f_layer,
  output logic                         core_data_in,
  input  logic                         core_sort_finish,
  input  logic                         core_data_out
);

  localparam int AW = $clog2(NUM_WORDS);
  localparam int NB = NUM_WORDS * WORD_W;
  localparam int CW = $clog2(NB);
  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int SW = WORD_W + AW;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRST,
    S_SHIFT,
    S_WAIT,
    S_CAPT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]     cnt;
  logic [AW-1:0]     widx;
  logic [BW-1:0]     bidx;
  logic [WORD_W-1:0] pat [NUM_WORDS];
  logic [WORD_W-1:0] res [NUM_WORDS];
  logic              launch;
  logic              fire_to;
  logic              ord_ok;
  logic [SW-1:0]     sum_pat;
  logic [SW-1:0]     sum_res;
  logic              pass_q;
  logic              f_layer_q;
  logic              crst_n_q;
  logic              cap_en;

  // One bit counter serves both directions: MSB first, word 0 first.
  assign widx = AW'(int'(cnt) / WORD_W);
  assign bidx = BW'(WORD_W - 1 - int'(cnt) % WORD_W);

  always_ff @(posedge t_clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    done     = 1'b0;
    busy     = (state != S_IDLE);
    unique case (state)
      S_IDLE: begin
        if (start) begin
          launch   = 1'b1;
          state_nx = S_CRST;
        end
      end
      S_CRST:  state_nx = S_SHIFT;
      S_SHIFT: if (cnt == LAST) state_nx = S_WAIT;
      S_WAIT: begin
        if (core_sort_finish) state_nx = S_CAPT;
        else if (fire_to)     state_nx = S_DONE;
      end
      S_CAPT:  if (cnt == LAST) state_nx = S_CHECK;
      S_CHECK: state_nx = S_DONE;
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge t_clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      unique case (state)
        S_SHIFT, S_CAPT: cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        S_WAIT:  cnt <= core_sort_finish ? CW'(1) : '0;
        default: cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge t_clk) begin
    if (wr_en && state == S_IDLE) pat[wr_addr] <= wr_data;
  end

  // The finishing WAIT edge already carries result bit 0.
  assign cap_en = (state == S_CAPT) ||
                  (state == S_WAIT && core_sort_finish);

  always_ff @(posedge t_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WORDS; i++) res[i] <= '0;
    end else if (cap_en) begin
      res[widx][bidx] <= core_data_out;
    end
  end

  assign rd_data = res[rd_addr];

  always_comb begin
    ord_ok  = 1'b1;
    sum_pat = '0;
    sum_res = '0;
    for (int i = 0; i < NUM_WORDS - 1; i++) begin
      if (res[i] > res[i+1]) ord_ok = 1'b0;
    end
    for (int i = 0; i < NUM_WORDS; i++) begin
      sum_pat = sum_pat + SW'(pat[i]);
      sum_res = sum_res + SW'(res[i]);
    end
  end

  always_ff @(posedge t_clk or posedge rst) begin
    if (rst) begin
      pass_q    <= 1'b0;
      f_layer_q <= 1'b0;
      crst_n_q  <= 1'b0;
    end else begin
      crst_n_q <= (state_nx != S_CRST);
      if (launch) begin
        pass_q    <= 1'b0;
        f_layer_q <= f_layer_cfg;
      end else if (state == S_CHECK) begin
        pass_q <= ord_ok && (sum_res == sum_pat);
      end
    end
  end

  assign pass         = pass_q;
  assign core_f_layer = f_layer_q;
  assign core_rst_n   = crst_n_q;
  assign core_data_in = (state == S_SHIFT) ? pat[widx][bidx] : 1'b0;

`ifdef LAYER_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] wcnt;
  logic          to_q;

  assign fire_to = (state == S_WAIT) && (wcnt == TO_LAST);

  always_ff @(posedge t_clk or posedge rst) begin
    if (rst) begin
      wcnt <= '0;
      to_q <= 1'b0;
    end else begin
      wcnt <= (state == S_WAIT) ? wcnt + TW'(1) : '0;
      if (launch) to_q <= 1'b0;
      else if (fire_to && !core_sort_finish) to_q <= 1'b1;
    end
  end

  assign timeout = to_q;
`else
  assign fire_to = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_layer_sort_seq.sv
// tb_layer_sort_seq: randomized/directed bench for layer_sort_seq.
// Plays the sort core role and checks against a reference model.

module tb_layer_sort_seq;

  logic       t_clk;
  logic       rst;
  logic       start;
  logic       f_layer_cfg;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [2:0] rd_addr;
  logic [3:0] rd_data;
  logic       busy;
  logic       done;
  logic       pass;
  logic       timeout;
  logic       core_rst_n;
  logic       core_f_layer;
  logic       core_data_in;
  logic       core_sort_finish;
  logic       core_data_out;

  int checks;
  int failures;
  int cyc;

  logic [3:0] pat_m [8];
  logic [3:0] ret_m [8];

  layer_sort_seq #(
    .WORD_W(4),
    .NUM_WORDS(8)
`ifdef LAYER_SEQ_TIMEOUT_EN
    ,
    .TIMEOUT(16)
`endif
  ) dut (
    .t_clk(t_clk),
    .rst(rst),
    .start(start),
    .f_layer_cfg(f_layer_cfg),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .busy(busy),
    .done(done),
    .pass(pass),
    .timeout(timeout),
    .core_rst_n(core_rst_n),
    .core_f_layer(core_f_layer),
    .core_data_in(core_data_in),
    .core_sort_finish(core_sort_finish),
    .core_data_out(core_data_out)
  );

  initial t_clk = 1'b0;
  always #5 t_clk = ~t_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  task automatic step();
    @(posedge t_clk);
    #1;
    cyc++;
  endtask

  function automatic logic pat_bit(input int k);
    logic [4:0] k5;
    logic [3:0] w;
    k5 = 5'(k);
    w = pat_m[k5[4:2]];
    return w[2'd3 - k5[1:0]];
  endfunction

  function automatic logic ret_bit(input int k);
    logic [4:0] k5;
    logic [3:0] w;
    k5 = 5'(k);
    w = ret_m[k5[4:2]];
    return w[2'd3 - k5[1:0]];
  endfunction

  // Reference verdict: non-decreasing and same total.
  function automatic logic ref_pass();
    int sp;
    int sr;
    logic ok;
    sp = 0;
    sr = 0;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sp += int'(pat_m[i]);
      sr += int'(ret_m[i]);
      if (i < 7 && ret_m[i] > ret_m[i+1]) ok = 1'b0;
    end
    return ok && (sp == sr);
  endfunction

  task automatic sort_ret();
    logic [3:0] t;
    for (int i = 0; i < 8; i++) ret_m[i] = pat_m[i];
    for (int i = 1; i < 8; i++) begin
      for (int j = i; j > 0; j--) begin
        if (ret_m[j-1] > ret_m[j]) begin
          t = ret_m[j];
          ret_m[j] = ret_m[j-1];
          ret_m[j-1] = t;
        end
      end
    end
  endtask

  task automatic load_pattern();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1;
      wr_addr = i[2:0];
      wr_data = pat_m[i];
      step();
    end
    wr_en = 1'b0;
  endtask

  // One full run with the core answering dly cycles after SHIFT ends.
  task automatic run_seq(input logic cfg, input int dly,
                         input bit inject, input logic exp_pass);
    int done_at;
    logic eb;
    start = 1'b1;
    f_layer_cfg = cfg;
    cyc = 0;
    step();
    start = 1'b0;
    f_layer_cfg = ~cfg;
    checks++;
    if ({busy, core_rst_n, pass, timeout, core_f_layer} !== {4'b1000, cfg}) begin
      failures++;
      $display("FAIL crst_cycle: got b/rn/p/t/f=%b expected %b",
               {busy, core_rst_n, pass, timeout, core_f_layer}, {4'b1000, cfg});
    end
    for (int c = 2; c <= 33; c++) begin
      step();
      wr_en = 1'b0;
      start = 1'b0;
      eb = pat_bit(c - 2);
      checks++;
      if ({core_data_in, core_rst_n, core_f_layer} !== {eb, 1'b1, cfg}) begin
        failures++;
        $display("FAIL shift_bit c=%0d: got din/rn/f=%b expected %b",
                 c, {core_data_in, core_rst_n, core_f_layer}, {eb, 1'b1, cfg});
      end
      if (inject && c == 5) begin
        wr_en = 1'b1;
        wr_addr = 3'd3;
        wr_data = 4'd9;
        start = 1'b1;
      end
    end
    for (int c = 34; c <= 33 + dly; c++) begin
      step();
      if (c == 34) begin
        checks++;
        if ({busy, core_data_in} !== 2'b10) begin
          failures++;
          $display("FAIL wait_entry: got busy/din=%b expected 10",
                   {busy, core_data_in});
        end
      end
      if (c == 33 + dly) begin
        core_sort_finish = 1'b1;
        core_data_out = ret_bit(0);
      end
    end
    for (int b = 1; b < 32; b++) begin
      step();
      core_sort_finish = 1'($urandom_range(0, 1));
      core_data_out = ret_bit(b);
    end
    done_at = -1;
    for (int n = 0; n < 8; n++) begin
      step();
      core_sort_finish = 1'b0;
      core_data_out = 1'b0;
      if (done === 1'b1) begin
        done_at = cyc;
        break;
      end
    end
    checks++;
    if (done_at != 66 + dly) begin
      failures++;
      $display("FAIL done_cycle: got %0d expected %0d", done_at, 66 + dly);
    end
    checks++;
    if ({pass, timeout} !== {exp_pass, 1'b0}) begin
      failures++;
      $display("FAIL verdict: got pass/to=%b expected %b",
               {pass, timeout}, {exp_pass, 1'b0});
    end
    step();
    checks++;
    if ({done, busy, pass, timeout} !== {2'b00, exp_pass, 1'b0}) begin
      failures++;
      $display("FAIL after_done: got d/b/p/t=%b expected %b",
               {done, busy, pass, timeout}, {2'b00, exp_pass, 1'b0});
    end
    for (int i = 0; i < 8; i++) begin
      rd_addr = i[2:0];
      #1;
      checks++;
      if (rd_data !== ret_m[i]) begin
        failures++;
        $display("FAIL rd_data[%0d]: got %0d expected %0d", i, rd_data, ret_m[i]);
      end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({busy, done, pass, timeout, core_rst_n, core_f_layer, core_data_in}
        !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 0000000",
               {busy, done, pass, timeout, core_rst_n, core_f_layer, core_data_in});
    end
    for (int i = 0; i < 8; i++) begin
      rd_addr = i[2:0];
      #1;
      checks++;
      if (rd_data !== 4'd0) begin
        failures++;
        $display("FAIL reset_result[%0d]: got %0d expected 0", i, rd_data);
      end
    end
    @(posedge t_clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, core_rst_n} !== 2'b00) begin
      failures++;
      $display("FAIL release_cycle: got busy/rn=%b expected 00", {busy, core_rst_n});
    end
    step();
    checks++;
    if ({busy, core_rst_n} !== 2'b01) begin
      failures++;
      $display("FAIL release_edge: got busy/rn=%b expected 01", {busy, core_rst_n});
    end
  endtask

  task automatic test_sorted_pass();
    pat_m = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd4, 4'd5, 4'd5, 4'd5};
    load_pattern();
    sort_ret();
    run_seq(1'b1, 15, 1'b0, 1'b1);
    rd_addr = 3'd7;
    #1;
    checks++;
    if (rd_data !== 4'd5) begin
      failures++;
      $display("FAIL rd7: got %0d expected 5", rd_data);
    end
  endtask

  task automatic test_min_latency();
    pat_m = '{4'd9, 4'd3, 4'd15, 4'd0, 4'd7, 4'd7, 4'd1, 4'd12};
    load_pattern();
    sort_ret();
    run_seq(1'b0, 1, 1'b0, 1'b1);
  endtask

  task automatic test_order_fail();
    pat_m = '{4'd12, 4'd13, 4'd14, 4'd15, 4'd12, 4'd13, 4'd14, 4'd15};
    load_pattern();
    ret_m = '{4'd12, 4'd12, 4'd13, 4'd13, 4'd14, 4'd14, 4'd15, 4'd14};
    run_seq(1'b1, 4, 1'b0, 1'b0);
  endtask

  task automatic test_sum_fail();
    sort_ret();
    ret_m[1] = ret_m[1] + 4'd1;
    run_seq(1'b0, 6, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int bad;
    pat_m = '{4'd8, 4'd2, 4'd6, 4'd4, 4'd1, 4'd3, 4'd5, 4'd7};
    load_pattern();
    sort_ret();
    run_seq(1'b1, 3, 1'b1, 1'b1);
    bad = 0;
    for (int n = 0; n < 50; n++) begin
      step();
      if (busy !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL single_run: got %0d busy/done cycles expected 0", bad);
    end
  endtask

  task automatic test_timeout();
`ifdef LAYER_SEQ_TIMEOUT_EN
    int done_at;
    start = 1'b1;
    cyc = 0;
    step();
    start = 1'b0;
    done_at = -1;
    for (int n = 0; n < 80; n++) begin
      step();
      if (done === 1'b1) begin
        done_at = cyc;
        break;
      end
    end
    checks++;
    if (done_at != 50) begin
      failures++;
      $display("FAIL timeout_cycle: got %0d expected 50", done_at);
    end
    checks++;
    if ({pass, timeout} !== 2'b01) begin
      failures++;
      $display("FAIL timeout_flags: got pass/to=%b expected 01", {pass, timeout});
    end
    step();
    checks++;
    if ({busy, pass, timeout} !== 3'b001) begin
      failures++;
      $display("FAIL timeout_hold: got b/p/t=%b expected 001",
               {busy, pass, timeout});
    end
`else
    int bad;
    start = 1'b1;
    step();
    start = 1'b0;
    bad = 0;
    for (int n = 0; n < 2000; n++) begin
      step();
      if (busy !== 1'b1 || done !== 1'b0 || timeout !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL no_timeout: got %0d bad cycles expected 0", bad);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
`endif
  endtask

  task automatic test_reset_mid_shift();
    int bad;
    start = 1'b1;
    cyc = 0;
    step();
    start = 1'b0;
    while (cyc < 10) step();
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, core_rst_n, core_data_in, done} !== 4'b0000) begin
      failures++;
      $display("FAIL mid_reset: got b/rn/din/d=%b expected 0000",
               {busy, core_rst_n, core_data_in, done});
    end
    bad = 0;
    for (int n = 0; n < 3; n++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    rst = 1'b0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL mid_reset_done: got %0d bad cycles expected 0", bad);
    end
    sort_ret();
    run_seq(1'b1, 2, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    int kind;
    int a;
    int b;
    logic [3:0] t;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 8; i++) pat_m[i] = 4'($urandom_range(0, 15));
      load_pattern();
      sort_ret();
      kind = $urandom_range(0, 2);
      a = $urandom_range(0, 7);
      b = $urandom_range(0, 7);
      if (kind == 1) begin
        t = ret_m[a];
        ret_m[a] = ret_m[b];
        ret_m[b] = t;
      end else if (kind == 2) begin
        ret_m[a] = ret_m[a] + 4'd1;
      end
      run_seq(1'($urandom_range(0, 1)), $urandom_range(1, 20), 1'b0, ref_pass());
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    rst = 1'b1;
    start = 1'b0;
    f_layer_cfg = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    core_sort_finish = 1'b0;
    core_data_out = 1'b0;
    test_reset();
    test_sorted_pass();
    test_min_latency();
    test_order_fail();
    test_sum_fail();
    test_back_to_back();
    test_timeout();
    test_reset_mid_shift();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/layer_sort_seq.md
# layer_sort_seq

Test sequencer for the per-layer sort core in the 3D self-test flow. Holds a pattern of NUM_WORDS words loaded over a parallel write port. On `start` it resets the sort core, shifts the pattern serially into it, and waits for `sort_finish`. It then deserialises the core's `data_out`, checks the result is non-decreasing with an unchanged sum, and reports pass/fail/timeout. It sits between the chip-level test controller and one sort core instance, which it drives exclusively.

## Interface
- `WORD_W`, 4, bits per word
- `NUM_WORDS`, 8, words per frame; power of two, ≥2
- `TIMEOUT`, 1024, maximum cycles spent in WAIT (only with the macro below)
- `t_clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  launch request; sampled only in IDLE
- `f_layer_cfg`  in  1  value for the core's `f_layer`; latched on `start`
- `wr_en`  in  1  pattern write strobe; ignored unless IDLE
- `wr_addr`  in  log2(NUM_WORDS)  pattern word index
- `wr_data`  in  WORD_W  pattern word
- `rd_addr`  in  log2(NUM_WORDS)  result word index
- `rd_data`  out  WORD_W  captured result word at `rd_addr`; combinational read
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when the run ends (pass, fail or timeout)
- `pass`  out  1  result of the last run; held until the next accepted `start`
- `timeout`  out  1  last run ended by timeout; held until the next accepted `start`
- `core_rst_n`  out  1  active-low reset to the sort core
- `core_f_layer`  out  1  to the core's `f_layer`
- `core_data_in`  out  1  serial pattern bit to the core
- `core_sort_finish`  in  1  core's `sort_finish`
- `core_data_out`  in  1  core's serial result bit

## Operation
- FSM states: IDLE → CRST → SHIFT → WAIT → CAPTURE → CHECK → DONE → IDLE.
- IDLE: writes to the pattern RAM are accepted. `start=1` latches `f_layer_cfg`, clears `pass` and `timeout`, and moves to CRST.
- CRST: lasts 1 cycle with `core_rst_n=0`. It is 1 in every other state.
- SHIFT: lasts exactly NUM_WORDS×WORD_W cycles. Words go out in order 0…NUM_WORDS-1, each MSB first, one bit per cycle on `core_data_in`.
- WAIT: `core_data_in` is held at 0.
  - If `core_sort_finish=1` on an edge, that edge samples the first result bit and the FSM moves to CAPTURE.
  - With the macro enabled, if TIMEOUT cycles elapse first, the FSM sets `timeout=1`, leaves `pass=0`, and goes to DONE.
- CAPTURE: samples the remaining NUM_WORDS×WORD_W−1 bits. Packing is MSB first, word 0 first, into the result RAM.
- CHECK: 1 cycle. `pass=1` iff both hold:
  - result[i] ≤ result[i+1] for all i;
  - the sum of results equals the sum of the pattern, computed unsigned in WORD_W+log2(NUM_WORDS) bits.
- DONE: `done=1` for 1 cycle, then IDLE.
- `start` outside IDLE is ignored. `wr_en` outside IDLE is ignored and the pattern RAM is unchanged.
- The pattern RAM is not reset. The result RAM resets to 0.

## Timing
- Reset values (while `rst` is high and in the cycle after release):
  - state IDLE;
  - `busy=0`, `done=0`, `pass=0`, `timeout=0`;
  - `core_rst_n=0`;
  - `core_f_layer=0`, `core_data_in=0`.
  - `core_rst_n` goes to 1 on the first edge after `rst` deasserts.
- Reset mid-run aborts immediately to the reset values. No `done` pulse is produced.
- Cycle numbering, with `start` sampled at edge 0:
  - cycle 1: CRST (`busy=1`, `core_rst_n=0`);
  - cycles 2…NUM_WORDS×WORD_W+1: SHIFT; with defaults, cycle 2 carries word0[3] and cycle 33 carries word7[0];
  - `core_f_layer` is valid from cycle 1 until the return to IDLE.
- Minimum run length, where finish is seen on the first WAIT edge: 1 + 32 + 1 + 31 + 1 + 1 = 67 cycles to `done` with defaults.
- `pass`/`timeout` are valid in the `done` cycle and stay stable afterwards.
- `core_sort_finish` dropping during CAPTURE is ignored. Exactly NUM_WORDS×WORD_W bits are always captured.
- The WAIT counter starts at 0 on WAIT entry. Timeout fires on the edge where the count reaches TIMEOUT−1.

## Configuration
- `LAYER_SEQ_TIMEOUT_EN` defined:
  - the WAIT watchdog and TIMEOUT parameter are active;
  - `timeout` behaves as above.
- Not defined:
  - WAIT waits indefinitely for `core_sort_finish`;
  - `timeout` is tied to 0;
  - no counter is synthesised.

## Test plan
- Reset mid-SHIFT: assert `rst` at cycle 10 → `busy=0`, `core_rst_n=0`, no `done`; after release, a new `start` runs a clean sequence.
- Load pattern 0,1,2,2,4,5,5,5, `f_layer_cfg=1`, `start`; core model returns the sorted stream 15 cycles after SHIFT ends → bits on `core_data_in` match MSB-first order; `done` at cycle 81; `pass=1`; `rd_data` at address 7 = 5.
- Pattern 12,13,14,15,12,13,14,15; core returns 12,12,13,13,14,14,15,14 → `pass=0` (order violation), `timeout=0`.
- Pattern as above; core returns the sorted stream with one word changed by +1 → `pass=0` (sum mismatch).
- With `LAYER_SEQ_TIMEOUT_EN` and `TIMEOUT=16`, core never finishes → `done` 16 cycles after WAIT entry, `timeout=1`, `pass=0`. Without the macro → `busy` stays 1 for 2000 cycles.
- `wr_en` asserted with address 3 and data 9 during a run, plus a second `start` mid-run → pattern word 3 unchanged and the run completes once.
